// File: rtl/pkt_burst_reader.sv
`default_nettype none
// ============================================================================
//  Module   : pkt_burst_reader
//  Purpose  : Avalon-MM burst read master. Fetches one packet from host
//             memory in the byte range [pkt_begin, pkt_end) and writes its
//             words into a capture FIFO. The packet is split into bursts of at
//             most MAX_BURST beats. A burst is issued only when the FIFO
//             reports room for the whole burst.
//  Ports    : clk, reset (sync, active-low)
//             start/pkt_begin/pkt_end      packet request
//             busy/done/words_read         status
//             fifo_space/fifo_data/fifo_wr capture FIFO side
//             address/read/burstcount/waitrequest/readdata/readdatavalid
//                                          Avalon-MM read master side
//  Revision : 1.0 - initial release
// ============================================================================
module pkt_burst_reader #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MAX_BURST = 16,
  parameter int BCNT_W    = 11,
  parameter int SPACE_W   = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_W-1:0]  pkt_begin,
  input  logic [ADDR_W-1:0]  pkt_end,
  output logic               busy,
  output logic               done,
  output logic [15:0]        words_read,
  input  logic [SPACE_W-1:0] fifo_space,
  output logic [DATA_W-1:0]  fifo_data,
  output logic               fifo_wr,
  output logic [ADDR_W-1:0]  address,
  output logic               read,
  output logic [BCNT_W-1:0]  burstcount,
  input  logic               waitrequest,
  input  logic [DATA_W-1:0]  readdata,
  input  logic               readdatavalid
);

  localparam int c_BYTES = DATA_W / 8;
  localparam int c_SHIFT = $clog2(c_BYTES);

  localparam logic [ADDR_W-1:0] c_LOW_MASK = ADDR_W'(c_BYTES - 1);
  localparam logic [ADDR_W:0]   c_ROUND    = (ADDR_W + 1)'(c_BYTES - 1);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_ISSUE = 2'd1;
  localparam logic [1:0] c_DATA  = 2'd2;
  localparam logic [1:0] c_DONE  = 2'd3;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_remaining;
  logic [BCNT_W-1:0] r_len;
  logic [BCNT_W-1:0] r_beats;

  logic [ADDR_W-1:0] w_begin_al;
  logic [ADDR_W:0]   w_span;
  logic [ADDR_W:0]   w_words;
  logic [15:0]       w_start_rem;
  logic [15:0]       w_len;
  logic [BCNT_W-1:0] w_len_b;
  logic              w_room;
  logic              w_last_beat;
  logic [15:0]       w_rem_next;
  logic [ADDR_W-1:0] w_addr_step;

  assign w_begin_al = pkt_begin & ~c_LOW_MASK;
  // One extra bit so the round-up addend cannot wrap a near-full span.
  assign w_span      = {1'b0, pkt_end - w_begin_al} + c_ROUND;
  assign w_words     = w_span >> c_SHIFT;
  assign w_start_rem = 16'(w_words);

  assign w_len   = (r_remaining > 16'(MAX_BURST)) ? 16'(MAX_BURST) : r_remaining;
  assign w_len_b = BCNT_W'(w_len);
  assign w_room  = 32'(fifo_space) >= 32'(w_len);

  assign w_last_beat = readdatavalid && (r_beats == (r_len - BCNT_W'(1)));
  assign w_rem_next  = r_remaining - 16'(r_len);
  assign w_addr_step = ADDR_W'(r_len) << c_SHIFT;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= c_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_len       <= '0;
      r_beats     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      words_read  <= '0;
      fifo_data   <= '0;
      fifo_wr     <= 1'b0;
      address     <= '0;
      read        <= 1'b0;
      burstcount  <= '0;
    end else begin
      fifo_wr <= 1'b0;
      done    <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (start) begin
            r_addr      <= w_begin_al;
            r_remaining <= w_start_rem;
            words_read  <= '0;
            busy        <= 1'b1;
            r_state     <= (w_start_rem == 16'd0) ? c_DONE : c_ISSUE;
          end
        end
        c_ISSUE: begin
          if (read) begin
            // Command is frozen while stalled, regardless of fifo_space.
            if (!waitrequest) begin
              read    <= 1'b0;
              r_beats <= '0;
              r_state <= c_DATA;
            end
          end else if (w_room) begin
            read       <= 1'b1;
            address    <= r_addr;
            burstcount <= w_len_b;
            r_len      <= w_len_b;
          end
        end
        c_DATA: begin
          if (readdatavalid) begin
            fifo_wr    <= 1'b1;
            fifo_data  <= readdata;
            words_read <= words_read + 16'd1;
            r_beats    <= r_beats + BCNT_W'(1);
            if (w_last_beat) begin
              r_remaining <= w_rem_next;
              r_addr      <= r_addr + w_addr_step;
              r_state     <= (w_rem_next == 16'd0) ? c_DONE : c_ISSUE;
            end
          end
        end
        c_DONE: begin
          // done and busy update together so the pulse coincides with busy=0.
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= c_IDLE;
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pkt_burst_reader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_pkt_burst_reader
//  Purpose  : Self-checking bench for pkt_burst_reader. An Avalon slave model
//             answers bursts; expected commands and FIFO words are queued by
//             the stimulus and consumed by independent checking processes.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pkt_burst_reader;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 32;
  localparam int MAX_BURST = 16;
  localparam int BCNT_W    = 11;
  localparam int SPACE_W   = 10;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               start = 1'b0;
  logic [ADDR_W-1:0]  pkt_begin = '0;
  logic [ADDR_W-1:0]  pkt_end = '0;
  logic               busy;
  logic               done;
  logic [15:0]        words_read;
  logic [SPACE_W-1:0] fifo_space = 10'd100;
  logic [DATA_W-1:0]  fifo_data;
  logic               fifo_wr;
  logic [ADDR_W-1:0]  address;
  logic               read;
  logic [BCNT_W-1:0]  burstcount;
  logic               waitrequest = 1'b0;
  logic [DATA_W-1:0]  readdata = '0;
  logic               readdatavalid = 1'b0;

  always #5 clk = ~clk;

  pkt_burst_reader #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_BURST(MAX_BURST),
    .BCNT_W(BCNT_W), .SPACE_W(SPACE_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .pkt_begin(pkt_begin),
    .pkt_end(pkt_end), .busy(busy), .done(done), .words_read(words_read),
    .fifo_space(fifo_space), .fifo_data(fifo_data), .fifo_wr(fifo_wr),
    .address(address), .read(read), .burstcount(burstcount),
    .waitrequest(waitrequest), .readdata(readdata),
    .readdatavalid(readdatavalid)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] exp_data[$];
  logic [63:0] exp_cmd[$];

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- Avalon slave model + command checker ----------------
  int          stall_cfg = 0;
  int          stall_left = 0;
  int          pend_beats = 0;
  logic [31:0] pend_addr = '0;
  bit          gap_mode = 0;
  bit          stray_req = 0;
  logic        prev_wait = 1'b0;
  logic        prev_read = 1'b0;
  logic [31:0] hold_addr = '0;
  logic [BCNT_W-1:0] hold_bc = '0;
  int          read_rise_cyc = -1;
  int          acc_cyc = -1;
  logic [63:0] cmd_e;

  always @(negedge clk) begin
    readdatavalid = 1'b0;
    if (!reset) begin
      pend_beats  = 0;
      stall_left  = 0;
      waitrequest = 1'b0;
      prev_wait   = 1'b0;
      prev_read   = 1'b0;
    end else begin
      if (pend_beats > 0 && !(gap_mode && (cyc % 3 == 0))) begin
        readdatavalid = 1'b1;
        readdata      = mem(pend_addr);
        pend_addr     = pend_addr + 32'd4;
        pend_beats--;
      end else if (stray_req) begin
        readdatavalid = 1'b1;
        readdata      = 32'hDEAD_BEEF;
        stray_req     = 0;
      end
      if (prev_wait) begin
        check("hold_read", 64'(read), 64'd1);
        check("hold_address", 64'(address), 64'(hold_addr));
        check("hold_burstcount", 64'(burstcount), 64'(hold_bc));
      end
      if (read && !prev_read) begin
        read_rise_cyc = cyc;
        stall_left    = stall_cfg;
        stall_cfg     = 0;
      end
      if (read && stall_left > 0) begin
        waitrequest = 1'b1;
        stall_left--;
        hold_addr = address;
        hold_bc   = burstcount;
      end else begin
        waitrequest = 1'b0;
        if (read) begin
          acc_cyc = cyc;
          check("no_overlap_beats", 64'(pend_beats), 64'd0);
          if (exp_cmd.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_cmd: got addr %0h bc %0d expected no command", address, burstcount);
          end else begin
            cmd_e = exp_cmd.pop_front();
            check("cmd_addr_bc", {address, 32'(burstcount)}, cmd_e);
          end
          pend_addr  = address;
          pend_beats = int'(burstcount);
        end
      end
      prev_wait = waitrequest;
      prev_read = read;
    end
  end

  // ---------------- FIFO / done monitor ----------------
  int          done_cnt = 0;
  int          done_cyc = -1;
  int          last_wr_cyc = -1;
  int          wr_cnt = 0;
  logic [31:0] data_e;

  always @(negedge clk) begin
    if (fifo_wr) begin
      last_wr_cyc = cyc;
      wr_cnt++;
      if (exp_data.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_fifo_wr: got data %0h expected no write", fifo_data);
      end else begin
        data_e = exp_data.pop_front();
        check("fifo_data", 64'(fifo_data), 64'(data_e));
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      check("busy_low_at_done", 64'(busy), 64'd0);
    end
  end

  // ---------------- stimulus ----------------
  int start_cyc = 0;
  int d0 = 0;

  task automatic push_words(input logic [31:0] b, input int n);
    for (int i = 0; i < n; i++) exp_data.push_back(mem(b + 32'(4 * i)));
  endtask

  task automatic start_pkt(input logic [31:0] b, input logic [31:0] e);
    pkt_begin = b;
    pkt_end   = e;
    start     = 1'b1;
    d0        = done_cnt;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 2000; i++) begin
      if (done_cnt != d0) break;
      @(negedge clk);
    end
    checks++;
    if (done_cnt == d0) begin
      errors++;
      $display("FAIL %s_timeout: got no done expected done within 2000 cycles", name);
    end
    repeat (3) @(negedge clk);
    check({name, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
    check({name, "_data_left"}, 64'(exp_data.size()), 64'd0);
    check({name, "_cmd_left"}, 64'(exp_cmd.size()), 64'd0);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_busy"}, 64'(busy), 64'd0);
    check({name, "_done"}, 64'(done), 64'd0);
    check({name, "_words_read"}, 64'(words_read), 64'd0);
    check({name, "_fifo_data"}, 64'(fifo_data), 64'd0);
    check({name, "_fifo_wr"}, 64'(fifo_wr), 64'd0);
    check({name, "_address"}, 64'(address), 64'd0);
    check({name, "_read"}, 64'(read), 64'd0);
    check({name, "_burstcount"}, 64'(burstcount), 64'd0);
  endtask

  int rr_before;
  int t_raise;
  int wr0;

  initial begin
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b1;
    @(negedge clk);

    // Single 4-word burst, no stalls.
    exp_cmd.push_back({32'h1000, 32'd4});
    push_words(32'h1000, 4);
    start_pkt(32'h1000, 32'h1010);
    check("t1_busy", 64'(busy), 64'd1);
    wait_done("t1");
    check("t1_latency", 64'(read_rise_cyc - start_cyc), 64'd2);
    check("t1_done_after_last_wr", 64'(done_cyc - last_wr_cyc), 64'd1);
    check("t1_words_read", 64'(words_read), 64'd4);

    // 40 words -> bursts 16,16,8 with gaps in the data stream.
    gap_mode = 1;
    exp_cmd.push_back({32'h2000, 32'd16});
    exp_cmd.push_back({32'h2040, 32'd16});
    exp_cmd.push_back({32'h2080, 32'd8});
    push_words(32'h2000, 40);
    start_pkt(32'h2000, 32'h20A0);
    wait_done("t2");
    check("t2_words_read", 64'(words_read), 64'd40);
    gap_mode = 0;

    // 5 stall cycles on the command; fifo_space drops while stalled.
    stall_cfg = 5;
    exp_cmd.push_back({32'h4000, 32'd4});
    push_words(32'h4000, 4);
    start_pkt(32'h4000, 32'h4010);
    for (int i = 0; i < 20 && !read; i++) @(negedge clk);
    fifo_space = 10'd0;
    wait_done("t3");
    fifo_space = 10'd100;
    check("t3_accept_cycle", 64'(acc_cyc - read_rise_cyc), 64'd5);
    check("t3_words_read", 64'(words_read), 64'd4);

    // Insufficient FIFO room holds off the read.
    fifo_space = 10'd3;
    exp_cmd.push_back({32'h1000, 32'd4});
    push_words(32'h1000, 4);
    start_pkt(32'h1000, 32'h1010);
    for (int i = 0; i < 6; i++) begin
      check("t4_read_low", 64'(read), 64'd0);
      @(negedge clk);
    end
    fifo_space = 10'd4;
    t_raise = cyc;
    wait_done("t4");
    fifo_space = 10'd100;
    check("t4_read_next_cycle", 64'(read_rise_cyc - t_raise), 64'd1);

    // Empty packet.
    rr_before = read_rise_cyc;
    start_pkt(32'h3000, 32'h3000);
    wait_done("t5");
    check("t5_done_latency", 64'(done_cyc - start_cyc), 64'd2);
    check("t5_words_read", 64'(words_read), 64'd0);
    check("t5_no_read", 64'(read_rise_cyc), 64'(rr_before));

    // Reset mid-DATA, stray beat, then a clean packet.
    exp_cmd.push_back({32'h2000, 32'd16});
    exp_cmd.push_back({32'h2040, 32'd16});
    exp_cmd.push_back({32'h2080, 32'd8});
    push_words(32'h2000, 40);
    wr0 = wr_cnt;
    start_pkt(32'h2000, 32'h20A0);
    for (int i = 0; i < 100 && (wr_cnt - wr0) < 3; i++) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("midreset");
    exp_data.delete();
    exp_cmd.delete();
    @(negedge clk);
    reset = 1'b1;
    stray_req = 1;
    repeat (3) @(negedge clk);
    check("t6_stray_no_wr", 64'(fifo_wr), 64'd0);
    check("t6_stray_words_read", 64'(words_read), 64'd0);
    check("t6_stray_busy", 64'(busy), 64'd0);
    exp_cmd.push_back({32'h5000, 32'd6});
    push_words(32'h5000, 6);
    start_pkt(32'h5000, 32'h5018);
    wait_done("t6");
    check("t6_words_read", 64'(words_read), 64'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no completion expected finish before 300us");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
